// File: rtl/array_loop_seq_pkg.sv
// ============================================================================
// Module   : array_loop_seq_pkg
// Brief    : Shared state encoding and index-width helper for array_loop_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

package array_loop_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    // One extra bit so the loop index can reach DEPTH without wrapping.
    function automatic int idx_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/array_loop_regfile.sv
// ============================================================================
// Module   : array_loop_regfile
// Brief    : DEPTH x WIDTH register array, one write port, two async reads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module array_loop_regfile #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr_a,
    output logic [WIDTH-1:0] o_rdata_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] w_mem_d [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        always_comb begin
            w_mem_d[g] = r_mem_q[g];
            if (i_we && (i_waddr == AW'(g))) begin
                w_mem_d[g] = i_wdata;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_mem_q[g] <= '0;
            end else begin
                r_mem_q[g] <= w_mem_d[g];
            end
        end
    end

    assign o_rdata_a = r_mem_q[i_raddr_a];
    assign o_rdata_b = r_mem_q[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/array_loop_seq.sv
// ============================================================================
// Module   : array_loop_seq
// Brief    : Bounded copy-loop sequencer over a small register array.
// Revision : 1.0
// ============================================================================
`default_nettype none

module array_loop_seq
    import array_loop_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int IW   = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [WIDTH-1:0] host_wdata,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             start,
    input  logic [IW-1:0]    init_idx,
    input  logic [IW-1:0]    lo,
    input  logic [IW-1:0]    hi,
    input  logic [IW-1:0]    src_off,
    output logic             busy,
    output logic             done,
    output logic [IW-1:0]    iter_cnt
);

    localparam logic [IW-1:0] c_DEPTH = IW'(DEPTH);

    seq_state_e       r_state_q, w_state_d;
    logic [IW-1:0]    r_idx_q, w_idx_d;
    logic [IW-1:0]    r_lo_q, w_lo_d;
    logic [IW-1:0]    r_hi_q, w_hi_d;
    logic [IW-1:0]    r_off_q, w_off_d;
    logic [IW-1:0]    r_iter_q, w_iter_d;
    logic [WIDTH-1:0] r_hold_q, w_hold_d;

    logic             w_cond;
    logic [AW-1:0]    w_src_addr;
    logic [WIDTH-1:0] w_src_data;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;

    assign w_cond     = (r_idx_q < r_hi_q) && (r_idx_q > r_lo_q) && (r_idx_q < c_DEPTH);
    assign w_src_addr = r_idx_q[AW-1:0] - r_off_q[AW-1:0];

    // The host owns the write port only while idle; its write lands on the
    // same edge that accepts a start, so the loop reads the new data.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = host_addr;
        w_wdata = host_wdata;
        if (r_state_q == WRITE) begin
            w_we    = 1'b1;
            w_waddr = r_idx_q[AW-1:0];
            w_wdata = r_hold_q;
        end else if (r_state_q == IDLE) begin
            w_we    = host_we;
        end
    end

    array_loop_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (rd_addr),
        .o_rdata_a (rd_data),
        .i_raddr_b (w_src_addr),
        .o_rdata_b (w_src_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_idx_q   <= '0;
            r_lo_q    <= '0;
            r_hi_q    <= '0;
            r_off_q   <= '0;
            r_iter_q  <= '0;
            r_hold_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_lo_q    <= w_lo_d;
            r_hi_q    <= w_hi_d;
            r_off_q   <= w_off_d;
            r_iter_q  <= w_iter_d;
            r_hold_q  <= w_hold_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE:    if (start) w_state_d = CHECK;
            CHECK:   w_state_d = w_cond ? READ : DONE;
            READ:    w_state_d = WRITE;
            WRITE:   w_state_d = CHECK;
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_idx_d  = r_idx_q;
        w_lo_d   = r_lo_q;
        w_hi_d   = r_hi_q;
        w_off_d  = r_off_q;
        w_iter_d = r_iter_q;
        w_hold_d = r_hold_q;
        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_idx_d  = init_idx;
                    w_lo_d   = lo;
                    w_hi_d   = hi;
                    w_off_d  = src_off;
                    w_iter_d = '0;
                end
            end
            READ: begin
                w_hold_d = w_src_data;
            end
            WRITE: begin
                w_idx_d  = r_idx_q + 1'b1;
                w_iter_d = r_iter_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (r_state_q != IDLE);
        done = (r_state_q == DONE);
    end

    assign iter_cnt = r_iter_q;

endmodule

`default_nettype wire

// File: doc/array_loop_seq.md
# array_loop_seq

Sequencer for a small register array that runs a bounded copy loop. For each index `i`, starting at a programmed value and continuing while `(i < hi) && (i > lo) && (i < DEPTH)`, it copies `mem[(i - src_off) mod DEPTH]` into `mem[i]`. It sits between a host command port and the array, owns every array write once a command starts, and gives the host a direct write/read path while idle. If the condition is false on entry, the command completes with zero iterations and the array is left untouched.

## Interface
- `DEPTH`, 4, number of array entries (power of two, ≥2)
- `WIDTH`, 4, bits per entry
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `host_we`  in  1  host write strobe (honoured only while idle)
- `host_addr`  in  $clog2(DEPTH)  host write address
- `host_wdata`  in  WIDTH  host write data
- `rd_addr`  in  $clog2(DEPTH)  read address (combinational read)
- `rd_data`  out  WIDTH  `mem[rd_addr]`
- `start`  in  1  command strobe (accepted only while idle)
- `init_idx`  in  IW  loop start value; IW = $clog2(DEPTH)+1
- `lo`  in  IW  exclusive lower bound
- `hi`  in  IW  exclusive upper bound
- `src_off`  in  IW  source distance
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle completion pulse
- `iter_cnt`  out  IW  iterations executed by the last command

## Operation
- States and transitions:
  - IDLE: `start` latches `lo`, `hi`, `src_off` and sets `i = init_idx`, then moves to CHECK.
  - CHECK: evaluates `cond = (i < hi) && (i > lo) && (i < DEPTH)`. True goes to READ; false goes to DONE.
  - READ: `hold <= mem[(i - src_off) mod DEPTH]`, then moves to WRITE.
  - WRITE: `mem[i] <= hold`, `i <= i + 1`, `iter_cnt <= iter_cnt + 1`, then moves to CHECK.
  - DONE: `done = 1`, then moves to IDLE.
- Arithmetic and widths:
  - All comparisons are unsigned at IW bits.
  - `i` never wraps: `i < DEPTH` is checked before any write, and IW is wide enough to hold DEPTH.
  - Source index is `(i - src_off)` truncated to $clog2(DEPTH) bits, i.e. wraps modulo DEPTH.
- `iter_cnt` clears on command acceptance and holds its final value until the next accepted `start`.
- `busy = (state != IDLE)`.
- `start` while busy is ignored; there is no queue.
- `host_we` while busy is dropped.
- `host_we` and `start` in the same idle cycle: the host write commits first and the loop sees the new data.
- `lo >= hi`, or `init_idx` outside the window: zero iterations, normal `done` pulse.
- Reset, including mid-command:
  - state goes to IDLE.
  - All `mem` entries, `hold`, `i` and `iter_cnt` clear to 0.
  - `busy = 0`, `done = 0`.
  - No partial write is retained beyond entries already committed before reset.

## Timing
- `start` sampled in cycle T; CHECK runs in T+1.
- Zero-iteration command: `done` high in T+2, `busy` low in T+3.
- N iterations: `done` in T+2+3N.
- A new `start` is accepted in the cycle after `done`.
- Array writes land at the clock edge ending WRITE; `rd_data` reflects them in the next cycle.
- `rd_data` is combinational from `mem`; it is valid during busy but may show intermediate values.
- Outputs after reset: `rd_data = 0`, `busy = 0`, `done = 0`, `iter_cnt = 0`.

## Structure
- Package `array_loop_seq_pkg` holds:
  - state enum `seq_state_e` (IDLE, CHECK, READ, WRITE, DONE);
  - helper function `idx_w(depth)` returning IW.
- Sub-module `array_loop_regfile`:
  - DEPTH×WIDTH storage with async clear;
  - one write port, muxed between host and sequencer by the top level;
  - two combinational read ports (host read, sequencer source).
- Top level holds the FSM, index/bounds registers and `hold`.

## Test plan
- Zero iterations:
  - Setup: host writes mem = {0:0x0, 1:0x5, 2:0x2, 3:0x3}.
  - Stimulus: start with `init_idx=0`, `lo=1`, `hi=4`, `src_off=0`.
  - Required: `done` at T+2, `iter_cnt=0`, mem unchanged (mem[0]=0x0, mem[3]=0x3).
- Normal copy, same preload:
  - Stimulus: start with `init_idx=2`, `lo=1`, `hi=4`, `src_off=2`.
  - Required: mem[2]=0x0, mem[3]=0x5, `iter_cnt=2`, `done` at T+8.
- Source wrap, preload {0:0x1, 1:0x2, 2:0x3, 3:0x4}:
  - Stimulus: start with `init_idx=1`, `lo=0`, `hi=3`, `src_off=3`.
  - Required: the index-1 iteration reads source (1−3) mod 4 = 2, so mem[1]=0x3; the index-2 iteration reads source 3, so mem[2]=0x4; `iter_cnt=2`.
- DEPTH guard:
  - Stimulus: `init_idx=3`, `lo=0`, `hi=7`.
  - Required: exactly one iteration; no write beyond index 3.
- Ignored requests:
  - Stimulus: second `start` and a `host_we` to address 0 asserted while busy.
  - Required: both ignored; the first command's result and `iter_cnt` are unaffected.
- Async reset mid-command:
  - Stimulus: assert `rst` during a WRITE state.
  - Required: `busy=0` immediately, all mem entries 0, no `done` pulse.
  - After release: a zero-iteration command behaves as in the first scenario.
